// File: rtl/raster_pkg.sv
// Shared raster types, status codes and vertex-index helper
// for the triangle setup slice.
package raster_pkg;

   localparam int RASTER_CW = 32;
   localparam int PIX_W     = RASTER_CW / 2;

   localparam logic [1:0] STATUS_OK        = 2'd0;
   localparam logic [1:0] STATUS_CULLED    = 2'd1;
   localparam logic [1:0] STATUS_OFFSCREEN = 2'd2;

   typedef logic signed [RASTER_CW-1:0] coord_t;

   typedef struct packed {
      coord_t inv_w;
      coord_t z;
      coord_t y;
      coord_t x;
   } screen_vert_t;

   typedef logic signed [PIX_W-1:0] pix_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_MUL,
      ST_AREA,
      ST_CULL,
      ST_BBOX,
      ST_DONE
   } setup_state_t;

   function automatic logic [1:0] next_vert(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

endpackage

// File: rtl/tri_bbox.sv
// Min/max of three pixel coordinates, clamped to [0, LIMIT-1],
// with a flag for spans lying wholly outside that range.
module tri_bbox
   import raster_pkg::*;
#(
   parameter int LIMIT = 320
) (
   input  pix_t             c0,
   input  pix_t             c1,
   input  pix_t             c2,
   output logic [PIX_W-1:0] lo,
   output logic [PIX_W-1:0] hi,
   output logic             offscreen
);

   localparam pix_t EDGE = pix_t'(LIMIT - 1);

   pix_t mn;
   pix_t mx;

   always_comb begin
      mn = (c0 < c1) ? c0 : c1;
      if (c2 < mn) mn = c2;
      mx = (c0 > c1) ? c0 : c1;
      if (c2 > mx) mx = c2;
      offscreen = mx[PIX_W-1] || (mn > EDGE);
      lo = mn[PIX_W-1] ? '0 : (mn > EDGE) ? EDGE : mn;
      hi = mx[PIX_W-1] ? '0 : (mx > EDGE) ? EDGE : mx;
   end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: edge functions, doubled area, culling and bbox.
// Optional BACKFACE_CULL_EN culls negative-area triangles instead of flipping them.
module triangle_setup
   import raster_pkg::*;
#(
   parameter int COORD_WIDTH = 32,
   parameter int FB_WIDTH    = 320,
   parameter int FB_HEIGHT   = 180
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                start,
   input  logic [2:0][3:0][COORD_WIDTH-1:0]    verts_in,
   output logic [2:0][2*COORD_WIDTH-1:0]       edge_a,
   output logic [2:0][2*COORD_WIDTH-1:0]       edge_b,
   output logic [2:0][2*COORD_WIDTH-1:0]       edge_c,
   output logic [2*COORD_WIDTH-1:0]            area2,
   output logic [COORD_WIDTH/2-1:0]            bbox_min_x,
   output logic [COORD_WIDTH/2-1:0]            bbox_max_x,
   output logic [COORD_WIDTH/2-1:0]            bbox_min_y,
   output logic [COORD_WIDTH/2-1:0]            bbox_max_y,
   output logic [2:0][COORD_WIDTH-1:0]         z_out,
   output logic [2:0][COORD_WIDTH-1:0]         inv_w_out,
   output logic                                valid,
   output logic                                busy,
   output logic [1:0]                          status,
   output logic                                done
);

   localparam int CW = COORD_WIDTH;
   localparam int PW = CW / 2;
   localparam int EW = 2 * CW;
   localparam logic [2:0] MUL_LAST = 3'd5;

   setup_state_t state_q, state_d;

   logic [2:0]           cnt_q;
   pix_t                 px_q [3];
   pix_t                 py_q [3];
   logic signed [EW-1:0] a_q [3];
   logic signed [EW-1:0] b_q [3];
   logic signed [EW-1:0] c_q [3];
   logic signed [EW-1:0] area_q;
   logic [1:0]           status_q;

   logic [1:0]           e_idx, j_idx, k_idx;
   logic [1:0]           ma_idx, mb_idx;
   pix_t                 mul_a, mul_b;
   logic signed [CW-1:0] prod;
   logic signed [EW-1:0] prod_acc;

   logic [PW-1:0] xlo, xhi, ylo, yhi;
   logic          xoff, yoff;

   // Shared multiplier: even count takes +x_j*y_k, odd takes -x_k*y_j
   always_comb begin
      e_idx    = cnt_q[2:1];
      j_idx    = next_vert(e_idx);
      k_idx    = next_vert(j_idx);
      ma_idx   = cnt_q[0] ? k_idx : j_idx;
      mb_idx   = cnt_q[0] ? j_idx : k_idx;
      mul_a    = px_q[ma_idx];
      mul_b    = py_q[mb_idx];
      prod     = CW'(mul_a) * CW'(mul_b);
      prod_acc = cnt_q[0] ? -EW'(prod) : EW'(prod);
   end

   tri_bbox #(.LIMIT(FB_WIDTH)) u_bbox_x (
      .c0(px_q[0]), .c1(px_q[1]), .c2(px_q[2]),
      .lo(xlo), .hi(xhi), .offscreen(xoff)
   );

   tri_bbox #(.LIMIT(FB_HEIGHT)) u_bbox_y (
      .c0(py_q[0]), .c1(py_q[1]), .c2(py_q[2]),
      .lo(ylo), .hi(yhi), .offscreen(yoff)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = ST_CONVERT;
         ST_CONVERT: state_d = ST_MUL;
         ST_MUL:     if (cnt_q == MUL_LAST) state_d = ST_AREA;
         ST_AREA:    state_d = ST_CULL;
         ST_CULL:    state_d = ST_BBOX;
         ST_BBOX:    state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != ST_IDLE);
      done  = (state_q == ST_DONE);
      valid = done && (status_q == STATUS_OK);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q      <= '0;
         area_q     <= '0;
         status_q   <= STATUS_OK;
         bbox_min_x <= '0;
         bbox_max_x <= '0;
         bbox_min_y <= '0;
         bbox_max_y <= '0;
         z_out      <= '0;
         inv_w_out  <= '0;
         for (int i = 0; i < 3; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            c_q[i]  <= '0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: if (start) begin
               for (int i = 0; i < 3; i++) begin
                  px_q[i]      <= verts_in[i][0][CW-1:PW];
                  py_q[i]      <= verts_in[i][1][CW-1:PW];
                  z_out[i]     <= verts_in[i][2];
                  inv_w_out[i] <= verts_in[i][3];
               end
            end
            ST_CONVERT: begin
               cnt_q <= '0;
               for (int i = 0; i < 3; i++) begin
                  a_q[i] <= EW'(py_q[(i+1)%3]) - EW'(py_q[(i+2)%3]);
                  b_q[i] <= EW'(px_q[(i+2)%3]) - EW'(px_q[(i+1)%3]);
                  c_q[i] <= '0;
               end
            end
            ST_MUL: begin
               c_q[e_idx] <= c_q[e_idx] + prod_acc;
               cnt_q      <= cnt_q + 3'd1;
            end
            ST_AREA: area_q <= c_q[0] + c_q[1] + c_q[2];
            ST_CULL: begin
               status_q <= STATUS_OK;
               if (area_q == '0) begin
                  status_q <= STATUS_CULLED;
               end else if (area_q[EW-1]) begin
`ifdef BACKFACE_CULL_EN
                  status_q <= STATUS_CULLED;
`else
                  area_q <= -area_q;
                  for (int i = 0; i < 3; i++) begin
                     a_q[i] <= -a_q[i];
                     b_q[i] <= -b_q[i];
                     c_q[i] <= -c_q[i];
                  end
`endif
               end
            end
            ST_BBOX: begin
               bbox_min_x <= xlo;
               bbox_max_x <= xhi;
               bbox_min_y <= ylo;
               bbox_max_y <= yhi;
               if (status_q != STATUS_CULLED && (xoff || yoff))
                  status_q <= STATUS_OFFSCREEN;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         edge_a[i] = a_q[i];
         edge_b[i] = b_q[i];
         edge_c[i] = c_q[i];
      end
      area2  = area_q;
      status = status_q;
   end

endmodule

// File: tb/tb_triangle_setup.sv
// Directed scoreboard bench for triangle_setup: each accepted start
// pushes a reference result that is popped and checked on done.
module tb_triangle_setup;
   import raster_pkg::*;

   localparam int FBW = 320;
   localparam int FBH = 180;

   typedef struct packed {
      logic [2:0][63:0] a;
      logic [2:0][63:0] b;
      logic [2:0][63:0] c;
      logic [63:0]      area;
      logic [15:0]      minx, maxx, miny, maxy;
      logic [1:0]       status;
      logic             valid;
      logic [2:0][31:0] z;
      logic [2:0][31:0] w;
   } exp_t;

   logic                     clk_in = 1'b0;
   logic                     rst_in;
   logic                     start;
   logic [2:0][3:0][31:0]    verts_in;
   logic [2:0][63:0]         edge_a, edge_b, edge_c;
   logic [63:0]              area2;
   logic [15:0]              bbox_min_x, bbox_max_x;
   logic [15:0]              bbox_min_y, bbox_max_y;
   logic [2:0][31:0]         z_out, inv_w_out;
   logic                     valid, busy, done;
   logic [1:0]               status;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk_in = ~clk_in;

   triangle_setup #(
      .COORD_WIDTH(32), .FB_WIDTH(FBW), .FB_HEIGHT(FBH)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start(start),
      .verts_in(verts_in),
      .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c),
      .area2(area2),
      .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
      .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
      .z_out(z_out), .inv_w_out(inv_w_out),
      .valid(valid), .busy(busy), .status(status), .done(done)
   );

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clampv(input longint v, input longint lim);
      if (v < 0) return 0;
      if (v > lim - 1) return lim - 1;
      return v;
   endfunction

   function automatic exp_t model(input int vx[3], input int vy[3],
                                  input logic [2:0][31:0] z,
                                  input logic [2:0][31:0] w);
      exp_t   e;
      longint px[3], py[3], a[3], b[3], c[3];
      longint area, mnx, mxx, mny, mxy;
      int     st;
      area = 0;
      for (int i = 0; i < 3; i++) begin
         px[i] = longint'(vx[i] >>> 16);
         py[i] = longint'(vy[i] >>> 16);
      end
      for (int i = 0; i < 3; i++) begin
         a[i] = py[(i+1)%3] - py[(i+2)%3];
         b[i] = px[(i+2)%3] - px[(i+1)%3];
         c[i] = px[(i+1)%3] * py[(i+2)%3] - px[(i+2)%3] * py[(i+1)%3];
         area += c[i];
      end
      st = 0;
      if (area == 0) st = 1;
      else if (area < 0) begin
`ifdef BACKFACE_CULL_EN
         st = 1;
`else
         for (int i = 0; i < 3; i++) begin
            a[i] = -a[i];
            b[i] = -b[i];
            c[i] = -c[i];
         end
         area = -area;
`endif
      end
      mnx = px[0]; mxx = px[0]; mny = py[0]; mxy = py[0];
      for (int i = 1; i < 3; i++) begin
         if (px[i] < mnx) mnx = px[i];
         if (px[i] > mxx) mxx = px[i];
         if (py[i] < mny) mny = py[i];
         if (py[i] > mxy) mxy = py[i];
      end
      if (st == 0 && (mxx < 0 || mnx > FBW - 1 || mxy < 0 || mny > FBH - 1))
         st = 2;
      for (int i = 0; i < 3; i++) begin
         e.a[i] = a[i];
         e.b[i] = b[i];
         e.c[i] = c[i];
      end
      e.area   = area;
      e.minx   = 16'(clampv(mnx, FBW));
      e.maxx   = 16'(clampv(mxx, FBW));
      e.miny   = 16'(clampv(mny, FBH));
      e.maxy   = 16'(clampv(mxy, FBH));
      e.status = 2'(st);
      e.valid  = (st == 0);
      e.z      = z;
      e.w      = w;
      return e;
   endfunction

   // Drives one start pulse; the accept edge is consumed here.
   task automatic launch(input int x0, input int y0, input int x1,
                         input int y1, input int x2, input int y2,
                         input int frac, input bit push);
      screen_vert_t     v;
      int               vx[3], vy[3];
      logic [2:0][31:0] zs, ws;
      vx[0] = x0 * 65536 + frac; vy[0] = y0 * 65536 + frac;
      vx[1] = x1 * 65536 + frac; vy[1] = y1 * 65536 + frac;
      vx[2] = x2 * 65536 + frac; vy[2] = y2 * 65536 + frac;
      for (int i = 0; i < 3; i++) begin
         v.x     = vx[i];
         v.y     = vy[i];
         v.z     = $urandom;
         v.inv_w = $urandom;
         zs[i]   = v.z;
         ws[i]   = v.inv_w;
         verts_in[i] = v;
      end
      if (push) sb.push_back(model(vx, vy, zs, ws));
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int f = 0; f < 4; f++)
            verts_in[i][f] = $urandom;
   endtask

   task automatic await_done(input string tag, input int cyc0);
      int   cyc;
      exp_t e;
      cyc = cyc0;
      chk({tag, ".busy"}, longint'(busy), 1);
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
      chk({tag, ".latency"}, cyc, 11);
      chk({tag, ".sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".valid"}, longint'(valid), longint'(e.valid));
         chk({tag, ".status"}, longint'(status), longint'(e.status));
         chk({tag, ".area2"}, $signed(area2), $signed(e.area));
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.A%0d", tag, i), $signed(edge_a[i]), $signed(e.a[i]));
            chk($sformatf("%s.B%0d", tag, i), $signed(edge_b[i]), $signed(e.b[i]));
            chk($sformatf("%s.C%0d", tag, i), $signed(edge_c[i]), $signed(e.c[i]));
            chk($sformatf("%s.z%0d", tag, i), longint'(z_out[i]), longint'(e.z[i]));
            chk($sformatf("%s.w%0d", tag, i), longint'(inv_w_out[i]), longint'(e.w[i]));
         end
         chk({tag, ".minx"}, longint'(bbox_min_x), longint'(e.minx));
         chk({tag, ".maxx"}, longint'(bbox_max_x), longint'(e.maxx));
         chk({tag, ".miny"}, longint'(bbox_min_y), longint'(e.miny));
         chk({tag, ".maxy"}, longint'(bbox_max_y), longint'(e.maxy));
         tick();
         chk({tag, ".done_drop"}, longint'(done), 0);
         chk({tag, ".busy_drop"}, longint'(busy), 0);
         chk({tag, ".status_hold"}, longint'(status), longint'(e.status));
      end
   endtask

   initial begin
      int ndone;
      rst_in   = 1'b1;
      start    = 1'b0;
      verts_in = '0;
      tick();
      tick();
      chk("rst.busy", longint'(busy), 0);
      chk("rst.done", longint'(done), 0);
      chk("rst.valid", longint'(valid), 0);
      chk("rst.status", longint'(status), 0);
      chk("rst.area2", $signed(area2), 0);
      chk("rst.maxx", longint'(bbox_max_x), 0);
      rst_in = 1'b0;
      tick();

      launch(10, 10, 50, 10, 10, 40, 0, 1'b1);
      await_done("basic", 1);
      chk("basic.area_k", $signed(area2), 1200);
      chk("basic.A0_k", $signed(edge_a[0]), -30);
      chk("basic.B0_k", $signed(edge_b[0]), -40);
      chk("basic.C0_k", $signed(edge_c[0]), 1900);
      chk("basic.C1_k", $signed(edge_c[1]), -300);
      chk("basic.C2_k", $signed(edge_c[2]), -400);
      chk("basic.bbox_k", {bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y},
          {16'd10, 16'd10, 16'd50, 16'd40});

      launch(10, 10, 10, 40, 50, 10, 0, 1'b1);
      await_done("winding", 1);
`ifdef BACKFACE_CULL_EN
      chk("winding.status_k", longint'(status), 1);
`else
      chk("winding.area_k", $signed(area2), 1200);
      chk("winding.A0_k", $signed(edge_a[0]), -30);
`endif

      launch(0, 0, 10, 10, 20, 20, 0, 1'b1);
      await_done("collinear", 1);
      chk("collinear.status_k", longint'(status), 1);

      launch(-20, -5, 400, 10, 100, 300, 32'h0000_C000, 1'b1);
      await_done("clamp", 1);
      chk("clamp.bbox_k", {bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y},
          {16'd0, 16'd0, 16'd319, 16'd179});

      launch(400, 10, 500, 10, 400, 50, 0, 1'b1);
      await_done("offscreen", 1);
      chk("offscreen.status_k", longint'(status), 2);

      for (int r = 0; r < 4; r++) begin
         launch(int'($urandom_range(460)) - 60, int'($urandom_range(310)) - 60,
                int'($urandom_range(460)) - 60, int'($urandom_range(310)) - 60,
                int'($urandom_range(460)) - 60, int'($urandom_range(310)) - 60,
                int'($urandom_range(65535)), 1'b1);
         await_done($sformatf("rand%0d", r), 1);
      end

      launch(10, 10, 50, 10, 10, 40, 0, 1'b1);
      tick(); tick(); tick();
      launch(0, 0, 10, 10, 20, 20, 0, 1'b0);
      await_done("ignore", 5);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("ignore.extra_done", ndone, 0);

      launch(10, 10, 50, 10, 10, 40, 0, 1'b0);
      tick(); tick(); tick(); tick();
      rst_in = 1'b1;
      tick();
      chk("abort.busy", longint'(busy), 0);
      chk("abort.done", longint'(done), 0);
      chk("abort.area2", $signed(area2), 0);
      chk("abort.A0", $signed(edge_a[0]), 0);
      rst_in = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort.no_done", ndone, 0);
      launch(-20, -5, 400, 10, 100, 300, 0, 1'b1);
      await_done("after_abort", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
